// File: rtl/unidad_control_multiciclo.sv
// Multicycle control unit for the MIPS-subset datapath (Moore FSM, registered outputs).
// Define UC_JUMP_EN to decode opcode 000010 as an unconditional jump.
module unidad_control_multiciclo #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtZero,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic               instr_done
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
`ifdef UC_JUMP_EN
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`endif

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_AND   = 3'b101;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_RWB,
        S_BRANCH,
        S_IMM_EX,
        S_IMM_WB,
        S_ERR
`ifdef UC_JUMP_EN
        ,
        S_JUMP
`endif
    } state_t;

    // *_rdy fields are qualified by mem_ready at the output pins
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_rdy;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr_rdy;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       illegal;
        logic       done;
        logic       done_rdy;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;

    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_addi;
    logic is_slti;
    logic is_andi;
    logic is_ori;
    logic is_imm;
    logic is_j;

    assign is_r    = (OP == OP_R);
    assign is_lw   = (OP == OP_LW);
    assign is_sw   = (OP == OP_SW);
    assign is_beq  = (OP == OP_BEQ);
    assign is_addi = (OP == OP_ADDI);
    assign is_slti = (OP == OP_SLTI);
    assign is_andi = (OP == OP_ANDI);
    assign is_ori  = (OP == OP_ORI);
    assign is_imm  = is_addi | is_slti | is_andi | is_ori;
`ifdef UC_JUMP_EN
    assign is_j    = (OP == OP_J);
`else
    assign is_j    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    is_r:            state_d = S_EXEC_R;
                    is_lw || is_sw:  state_d = S_MEMADR;
                    is_beq:          state_d = S_BRANCH;
                    is_imm:          state_d = S_IMM_EX;
`ifdef UC_JUMP_EN
                    is_j:            state_d = S_JUMP;
`endif
                    default:         state_d = S_ERR;
                endcase
            end
            S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IMM_EX: state_d = S_IMM_WB;
            S_IMM_WB: state_d = S_FETCH;
            S_ERR:    state_d = S_FETCH;
`ifdef UC_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are precomputed for the state being entered, so they register with it
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_rd    = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.ir_wr_rdy = 1'b1;
                ctrl_d.pc_wr_rdy = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b = 2'b11;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_d.mem_rd = 1'b1;
                ctrl_d.iord   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_wr     = 1'b1;
                ctrl_d.done       = 1'b1;
            end
            S_MEMWR: begin
                ctrl_d.mem_wr   = 1'b1;
                ctrl_d.iord     = 1'b1;
                ctrl_d.done_rdy = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl_d.reg_dst = 1'b1;
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.done    = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_op     = ALU_SUB;
                ctrl_d.pc_wr_cond = 1'b1;
                ctrl_d.pc_src     = 2'b01;
                ctrl_d.done       = 1'b1;
            end
            S_IMM_EX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                unique case (1'b1)
                    is_slti: ctrl_d.alu_op = ALU_SLT;
                    is_andi: begin
                        ctrl_d.alu_op   = ALU_AND;
                        ctrl_d.ext_zero = 1'b1;
                    end
                    is_ori: begin
                        ctrl_d.alu_op   = ALU_OR;
                        ctrl_d.ext_zero = 1'b1;
                    end
                    default: ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            S_IMM_WB: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.done   = 1'b1;
            end
            S_ERR: begin
                ctrl_d.illegal = 1'b1;
            end
`ifdef UC_JUMP_EN
            S_JUMP: begin
                ctrl_d.pc_wr  = 1'b1;
                ctrl_d.pc_src = 2'b10;
                ctrl_d.done   = 1'b1;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCWrite     = ctrl_q.pc_wr | (ctrl_q.pc_wr_rdy & mem_ready);
    assign PCWriteCond = ctrl_q.pc_wr_cond;
    assign PCSrc       = ctrl_q.pc_src;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_rd;
    assign MemWrite    = ctrl_q.mem_wr;
    assign IRWrite     = ctrl_q.ir_wr_rdy & mem_ready;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_wr;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ExtZero     = ctrl_q.ext_zero;
    assign ALUop       = ALUOP_W'(ctrl_q.alu_op);
    assign illegal     = ctrl_q.illegal;
    assign instr_done  = ctrl_q.done | (ctrl_q.done_rdy & mem_ready);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Table-driven testbench for unidad_control_multiciclo.
// Expected output words per cycle are hand-written constants.
module tb_unidad_control_multiciclo;

    logic       clk;
    logic       rst_n;
    logic [5:0] OP;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtZero;
    logic [2:0] ALUop;
    logic       illegal;
    logic       instr_done;

    unidad_control_multiciclo #(.OP_W(6), .ALUOP_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .OP(OP),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSrc(PCSrc),
        .IorD(IorD),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .RegDst(RegDst),
        .MemToReg(MemToReg),
        .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ExtZero(ExtZero),
        .ALUop(ALUop),
        .illegal(illegal),
        .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,PCSrc,IorD,MemRead,MemWrite,IRWrite,RegDst,
    //  MemToReg,RegWrite,ALUSrcA,ALUSrcB,ExtZero,ALUop,illegal,instr_done}
    logic [19:0] obs;
    assign obs = {PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite,
                  IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB,
                  ExtZero, ALUop, illegal, instr_done};

    localparam logic [19:0] Z0    = 20'b0_0_00_0_0_0_0_0_0_0_0_00_0_000_0_0;
    localparam logic [19:0] FET   = 20'b1_0_00_0_1_0_1_0_0_0_0_01_0_000_0_0;
    localparam logic [19:0] FETW  = 20'b0_0_00_0_1_0_0_0_0_0_0_01_0_000_0_0;
    localparam logic [19:0] DEC   = 20'b0_0_00_0_0_0_0_0_0_0_0_11_0_000_0_0;
    localparam logic [19:0] MADR  = 20'b0_0_00_0_0_0_0_0_0_0_1_10_0_000_0_0;
    localparam logic [19:0] MRD   = 20'b0_0_00_1_1_0_0_0_0_0_0_00_0_000_0_0;
    localparam logic [19:0] MWB   = 20'b0_0_00_0_0_0_0_0_1_1_0_00_0_000_0_1;
    localparam logic [19:0] MWR   = 20'b0_0_00_1_0_1_0_0_0_0_0_00_0_000_0_1;
    localparam logic [19:0] MWRW  = 20'b0_0_00_1_0_1_0_0_0_0_0_00_0_000_0_0;
    localparam logic [19:0] EXR   = 20'b0_0_00_0_0_0_0_0_0_0_1_00_0_010_0_0;
    localparam logic [19:0] RWB   = 20'b0_0_00_0_0_0_0_1_0_1_0_00_0_000_0_1;
    localparam logic [19:0] BR    = 20'b0_1_01_0_0_0_0_0_0_0_1_00_0_001_0_1;
    localparam logic [19:0] IADD  = 20'b0_0_00_0_0_0_0_0_0_0_1_10_0_000_0_0;
    localparam logic [19:0] ISLT  = 20'b0_0_00_0_0_0_0_0_0_0_1_10_0_100_0_0;
    localparam logic [19:0] IAND  = 20'b0_0_00_0_0_0_0_0_0_0_1_10_1_101_0_0;
    localparam logic [19:0] IOR   = 20'b0_0_00_0_0_0_0_0_0_0_1_10_1_011_0_0;
    localparam logic [19:0] IWB   = 20'b0_0_00_0_0_0_0_0_0_1_0_00_0_000_0_1;
    localparam logic [19:0] ERR   = 20'b0_0_00_0_0_0_0_0_0_0_0_00_0_000_1_0;
    localparam logic [19:0] JMP   = 20'b1_0_10_0_0_0_0_0_0_0_0_00_0_000_0_1;

    typedef struct {
        string            name;
        logic [5:0]       op;
        int               n;
        logic [0:9]       rdy;
        logic [0:9][19:0] e;
    } vec_t;

    vec_t vt[$];
    int   checks;
    int   failures;

    task automatic chk(input string nm, input logic [19:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, obs, exp, $time);
        end
    endtask

    task automatic addv(input string nm, input logic [5:0] op, input int n,
                        input logic [0:9] rdy, input logic [0:9][19:0] e);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.n    = n;
        v.rdy  = rdy;
        v.e    = e;
        vt.push_back(v);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_state_after_release", Z0);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        OP        = 6'b000000;
        mem_ready = 1'b1;

        addv("rtype", 6'b000000, 4, '1, {FET, DEC, EXR, RWB, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("lw", 6'b100011, 5, '1, {FET, DEC, MADR, MRD, MWB, Z0, Z0, Z0, Z0, Z0});
        addv("sw", 6'b101011, 4, '1, {FET, DEC, MADR, MWR, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("beq", 6'b000100, 3, '1, {FET, DEC, BR, Z0, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("addi", 6'b001000, 4, '1, {FET, DEC, IADD, IWB, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("slti", 6'b001010, 4, '1, {FET, DEC, ISLT, IWB, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("andi", 6'b001100, 4, '1, {FET, DEC, IAND, IWB, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("ori", 6'b001101, 4, '1, {FET, DEC, IOR, IWB, Z0, Z0, Z0, Z0, Z0, Z0});
`ifdef UC_JUMP_EN
        addv("jump", 6'b000010, 3, '1, {FET, DEC, JMP, Z0, Z0, Z0, Z0, Z0, Z0, Z0});
`else
        addv("jump_off", 6'b000010, 3, '1, {FET, DEC, ERR, Z0, Z0, Z0, Z0, Z0, Z0, Z0});
`endif
        addv("ill_3f", 6'b111111, 3, '1, {FET, DEC, ERR, Z0, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("ill_11", 6'b010001, 3, '1, {FET, DEC, ERR, Z0, Z0, Z0, Z0, Z0, Z0, Z0});
        addv("lw_wait", 6'b100011, 10, 10'b0011100011,
             {FETW, FETW, FET, DEC, MADR, MRD, MRD, MRD, MRD, MWB});
        addv("sw_wait", 6'b101011, 5, 10'b1110111111,
             {FET, DEC, MADR, MWRW, MWR, Z0, Z0, Z0, Z0, Z0});
        addv("rtype_again", 6'b000000, 4, '1, {FET, DEC, EXR, RWB, Z0, Z0, Z0, Z0, Z0, Z0});

        #2;
        chk("rst_state", Z0);
        release_reset();

        // R-type interrupted by reset in EXEC_R
        mem_ready = 1'b1;
        OP = 6'b000000;
        #1;
        chk("mid_fetch", FET);
        @(negedge clk);
        chk("mid_decode", DEC);
        @(negedge clk);
        chk("mid_exec_r", EXR);
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", Z0);
        @(posedge clk);
        #1;
        chk("held_in_reset", Z0);
        release_reset();

        foreach (vt[i]) begin
            OP = vt[i].op;
            for (int c = 0; c < vt[i].n; c++) begin
                mem_ready = vt[i].rdy[c];
                #1;
                chk($sformatf("%s_c%0d", vt[i].name, c), vt[i].e[c]);
                @(negedge clk);
            end
        end

        mem_ready = 1'b1;
        OP = 6'b000000;
        #1;
        chk("final_fetch", FET);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
